// File: rtl/lsu_pkg.sv
// ============================================================================
// Module  : lsu_pkg
// Purpose : Shared definitions for the load/store unit. Holds the funct3
//           codes, the FSM state encoding, the load lane-select/extend and
//           store merge helpers, and the request error check.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Select the addressed byte or half of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = word >> {lane, 3'b000};
    b       = shifted[7:0];
    h       = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    load_extend = {{24{b[7]}}, b};
      F3_H:    load_extend = {{16{h[15]}}, h};
      F3_BU:   load_extend = {24'h0, b};
      F3_HU:   load_extend = {16'h0, h};
      default: load_extend = word;
    endcase
  endfunction

  // Replace the addressed byte or half of a memory word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [31:0] res;
    res = word;
    if (f3 == F3_B) begin
      case (lane)
        2'd0:    res[7:0]   = wdata[7:0];
        2'd1:    res[15:8]  = wdata[7:0];
        2'd2:    res[23:16] = wdata[7:0];
        default: res[31:24] = wdata[7:0];
      endcase
    end else if (f3 == F3_H) begin
      if (lane[1]) res[31:16] = wdata[15:0];
      else         res[15:0]  = wdata[15:0];
    end else begin
      res = wdata;
    end
    store_merge = res;
  endfunction

  // Illegal funct3 or (when alignment checking is on) a misaligned address.
  function automatic logic req_error(input logic [2:0] f3,
                                     input logic       write,
                                     input logic [1:0] addr_lo,
                                     input logic       check_align);
    logic illegal;
    logic misaligned;
    illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                 (write && (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W));
    misaligned = check_align &&
                 ((((f3 == F3_H) || (f3 == F3_HU)) && addr_lo[0]) ||
                  ((f3 == F3_W) && (addr_lo != 2'b00)));
    req_error  = illegal || misaligned;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module  : lsu_align
// Purpose : Combinational data path of the load/store unit: extracts and
//           extends load data, and merges sub-word store data into the word
//           read back from memory.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  f3_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  assign load_o  = load_extend(word_i, f3_i, lane_i);
  assign merge_o = store_merge(word_i, wdata_i, f3_i, lane_i);

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module  : load_store_unit
// Purpose : Bridges CPU load/store requests onto a word-wide data memory.
//           Sub-word stores use a read-modify-write; bad requests are
//           answered with an error and never reach memory.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_done,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic              wr_q;
  logic [31:0]       rdata_q;
  logic [31:0]       merge_q;
  logic              done_q;
  logic              err_q;

  logic [31:0]       load_d;
  logic [31:0]       merge_d;
  logic              req_err;

  assign req_err = req_error(req_funct3, req_write, req_addr[1:0], CHECK_ALIGN);

  lsu_align u_align (
    .word_i  (mem_rdata),
    .wdata_i (wdata_q),
    .f3_i    (f3_q),
    .lane_i  (addr_q[1:0]),
    .load_o  (load_d),
    .merge_o (merge_d)
  );

  // Request sequencing FSM: latch on accept, read, optional write, respond.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            f3_q    <= req_funct3;
            wr_q    <= req_write;
            if (req_err) begin
              // Bad requests skip memory entirely and answer next cycle.
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_RESP;
            end else if (req_write && (req_funct3 == F3_W)) begin
              state_q <= ST_WR;
            end else begin
              state_q <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (wr_q) begin
            merge_q <= merge_d;
            state_q <= ST_WR;
          end else begin
            rdata_q <= load_d;
            done_q  <= 1'b1;
            state_q <= ST_RESP;
          end
        end
        ST_WR: begin
          done_q  <= 1'b1;
          state_q <= ST_RESP;
        end
        default: begin
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory strobes decode only from the state register.
  assign req_ready  = (state_q == ST_IDLE);
  assign mem_read   = (state_q == ST_RD);
  assign mem_write  = (state_q == ST_WR);
  assign mem_addr   = 32'({addr_q[ADDR_W-1:2], 2'b00});
  assign mem_wdata  = (f3_q == F3_W) ? wdata_q : merge_q;
  assign resp_done  = done_q;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module  : tb_load_store_unit
// Purpose : Scoreboard bench for load_store_unit with a behavioural data_mem.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_done;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          done_cyc;
    int          nreads;
    int          nwrites;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb_q[$];
  int          errors;
  int          checks;
  int          cyc;
  int          rd_cnt;
  int          wr_cnt;
  int          wr_total;
  logic [31:0] wr_addr_seen;
  logic [31:0] wr_data_seen;
  logic [31:0] last_rd;

  load_store_unit #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_done  (resp_done),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural data memory: combinational read, write on the clock edge.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: counts strobes per transaction and scores each response.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (mem_read) rd_cnt++;
      if (mem_write) begin
        wr_cnt++;
        wr_total++;
        wr_addr_seen = mem_addr;
        wr_data_seen = mem_wdata;
      end
      if (resp_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk({e.name, "_cycle"}, 32'(cyc), 32'(e.done_cyc));
          chk({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
          chk({e.name, "_rdata"}, resp_rdata, e.rdata);
          chk({e.name, "_reads"}, 32'(rd_cnt), 32'(e.nreads));
          chk({e.name, "_writes"}, 32'(wr_cnt), 32'(e.nwrites));
          if (e.nwrites == 1 && wr_cnt == 1) begin
            chk({e.name, "_waddr"}, wr_addr_seen, e.waddr);
            chk({e.name, "_wdata"}, wr_data_seen, e.wdata);
          end
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  // Wait for ready, present one request for its accept edge, queue its expectation.
  task automatic issue(input string nm, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd, input int lat,
                       input int nr, input int nw, input logic [31:0] e_wd);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    n = 0;
    while (!req_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    e.name     = nm;
    e.err      = e_err;
    e.rdata    = e_rd;
    e.done_cyc = cyc + lat;
    e.nreads   = nr;
    e.nwrites  = nw;
    e.waddr    = {addr[31:2], 2'b00};
    e.wdata    = e_wd;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_load(input string nm, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] exp);
    last_rd = exp;
    issue(nm, 1'b0, f3, addr, 32'h0, 1'b0, exp, 2, 1, 0, 32'h0);
  endtask

  task automatic do_store(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_word);
    if (f3 == 3'b010) issue(nm, 1'b1, f3, addr, wd, 1'b0, last_rd, 2, 0, 1, exp_word);
    else              issue(nm, 1'b1, f3, addr, wd, 1'b0, last_rd, 3, 1, 1, exp_word);
  endtask

  task automatic do_err(input string nm, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr);
    issue(nm, wr, f3, addr, 32'hDEADBEEF, 1'b1, last_rd, 1, 0, 0, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      chk("drain_pending", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    int wr_before;
    errors     = 0;
    checks     = 0;
    cyc        = 0;
    rd_cnt     = 0;
    wr_cnt     = 0;
    wr_total   = 0;
    last_rd    = 32'h0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899AABB;

    // Reset values
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_done", {31'd0, resp_done}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);

    // Full-word store then read back
    do_store("sw_20", 3'b010, 32'h20, 32'h11223344, 32'h11223344);
    do_load("lw_20", 3'b010, 32'h20, 32'h11223344);

    // Sub-word loads with extension
    do_load("lb_13", 3'b000, 32'h13, 32'hFFFFFF88);
    do_load("lbu_13", 3'b100, 32'h13, 32'h00000088);
    do_load("lh_12", 3'b001, 32'h12, 32'hFFFF8899);
    do_load("lhu_10", 3'b101, 32'h10, 32'h0000AABB);
    do_load("lb_10", 3'b000, 32'h10, 32'hFFFFFFBB);
    do_load("lbu_11", 3'b100, 32'h11, 32'h000000AA);

    // Read-modify-write stores
    do_store("sb_11", 3'b000, 32'h11, 32'h000000A5, 32'h8899A5BB);
    do_store("sh_12", 3'b001, 32'h12, 32'h00001234, 32'h1234A5BB);
    do_load("lw_10", 3'b010, 32'h10, 32'h1234A5BB);

    // Errors: no strobes, rdata held
    do_err("lw_12_mis", 1'b0, 3'b010, 32'h12);
    do_err("sh_13_mis", 1'b1, 3'b001, 32'h13);
    do_err("f3_011", 1'b0, 3'b011, 32'h10);
    do_err("sbu_illegal", 1'b1, 3'b100, 32'h10);
    drain();
    chk("mem_after_errors", mem[4], 32'h1234A5BB);

    // Reset during the read phase of an RMW cancels the write
    mem[4] = 32'h8899AABB;
    wr_before = wr_total;
    @(posedge clk); #1;
    req_write  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h10;
    req_wdata  = 32'h000000EE;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rmw_in_rd", {31'd0, mem_read}, 32'd1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rmw_rst_writes", 32'(wr_total - wr_before), 32'd0);
    chk("rmw_rst_word", mem[4], 32'h8899AABB);
    chk("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rmw_rst_rdata", resp_rdata, 32'h0);
    last_rd = 32'h0;
    do_load("lw_after_rst", 3'b010, 32'h10, 32'h8899AABB);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
